// File: rtl/scv_pkg.sv
`default_nettype none
// ============================================================================
// Module : scv_pkg
// Brief  : Shared constants, RAM grant encoding and window decode for the SCV VRAM port.
// Rev    : 1.0  initial release
// ============================================================================
package scv_pkg;

  localparam int          VRAM_AW   = 10;
  localparam logic [15:0] VRAM_BASE = 16'h3000;

  typedef enum logic [2:0] {
    GNT_NONE,
    GNT_CPU_WR,
    GNT_CPU_RD,
    GNT_CLR,
    GNT_VID
  } gnt_e;

  // The window is 2^aw aligned, so decode only the bits above the offset.
  function automatic logic vram_sel(input logic [15:0] addr,
                                    input logic [15:0] base,
                                    input int          aw);
    logic [15:0] mask;
    mask = 16'hFFFF << aw;
    return (addr & mask) == base;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scv_vram_port_if.sv
`default_nettype none
// ============================================================================
// Module : scv_vram_port_if
// Brief  : CPU strobe bus plus video fetch channel of the SCV VRAM port.
// Rev    : 1.0  initial release
// ============================================================================
interface scv_vram_port_if
  import scv_pkg::*;
#(
  parameter int AW = VRAM_AW
);

  logic [15:0]   A;
  logic [7:0]    DB_I;
  logic          RDB;
  logic          WRB;
  logic [7:0]    DB_O;
  logic          DB_OE;
  logic          VID_REQ;
  logic [AW-1:0] VID_A;
  logic          VID_ACK;
  logic [7:0]    VID_D;
  logic          VID_DV;
  logic          BUSY;

  modport master (
    output A, DB_I, RDB, WRB, VID_REQ, VID_A,
    input  DB_O, DB_OE, VID_ACK, VID_D, VID_DV, BUSY
  );

  modport slave (
    input  A, DB_I, RDB, WRB, VID_REQ, VID_A,
    output DB_O, DB_OE, VID_ACK, VID_D, VID_DV, BUSY
  );

endinterface
`default_nettype wire

// File: rtl/scv_spram.sv
`default_nettype none
// ============================================================================
// Module : scv_spram
// Brief  : Single-port synchronous RAM; write on the edge, registered read.
// Rev    : 1.0  initial release
// ============================================================================
module scv_spram #(
  parameter int AW = 10,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_rdata;

  // Read data only moves on read cycles, so a consumer may sample it later.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/scv_vram_port.sv
`default_nettype none
// ============================================================================
// Module : scv_vram_port
// Brief  : uPD7800 bus responder for SCV VRAM, time-sharing one RAM with video fetch.
// Config : SCV_VRAM_PORT_CLR_EN adds a post-reset zero-fill sequencer (BUSY).
// Rev    : 1.0  initial release
// ============================================================================
module scv_vram_port
  import scv_pkg::*;
#(
  parameter int          AW   = VRAM_AW,
  parameter logic [15:0] BASE = VRAM_BASE
) (
  input  logic           CLK,
  input  logic           RES,
  scv_vram_port_if.slave bus
);

  logic          w_sel;
  logic          w_rd_start;
  logic          w_rd_rise;
  logic          w_wr_active;
  logic          w_wr_trail;

  logic          r_rdb_q;
  logic          r_wrb_q;
  logic          r_rd_pend;
  logic [AW-1:0] r_rd_addr;
  logic          r_wr_hit;
  logic          r_wr_pend;
  logic [AW-1:0] r_wr_addr;
  logic [7:0]    r_wr_data;
  logic          r_rd_q;
  logic [7:0]    r_db_hold;
  logic          r_rd_valid;
  logic          r_vid_ack;
  logic [7:0]    r_vid_d;
  logic          r_vid_dv;

  logic          w_clr_active;
  logic [AW-1:0] w_clr_addr;

  gnt_e          w_gnt;
  logic          w_ram_en;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [7:0]    w_ram_wdata;
  logic [7:0]    w_ram_rdata;

  assign w_sel       = vram_sel(bus.A, BASE, AW);
  assign w_rd_start  = r_rdb_q & ~bus.RDB & w_sel;
  assign w_rd_rise   = ~r_rdb_q & bus.RDB;
  assign w_wr_active = ~bus.WRB & w_sel;
  assign w_wr_trail  = ~r_wrb_q & bus.WRB;

  // Fixed-priority arbiter; the write pend always retires before a read so
  // a read-after-write to the same byte sees the new value.
  always_comb begin
    w_gnt       = GNT_NONE;
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = '0;
    w_ram_wdata = '0;
    if (r_wr_pend) begin
      w_gnt       = GNT_CPU_WR;
      w_ram_en    = 1'b1;
      w_ram_we    = 1'b1;
      w_ram_addr  = r_wr_addr;
      w_ram_wdata = r_wr_data;
    end else if (r_rd_pend) begin
      w_gnt      = GNT_CPU_RD;
      w_ram_en   = 1'b1;
      w_ram_addr = r_rd_addr;
    end else if (w_clr_active) begin
      w_gnt      = GNT_CLR;
      w_ram_en   = 1'b1;
      w_ram_we   = 1'b1;
      w_ram_addr = w_clr_addr;
    end else if (bus.VID_REQ && !r_vid_ack) begin
      w_gnt      = GNT_VID;
      w_ram_en   = 1'b1;
      w_ram_addr = bus.VID_A;
    end
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_rdb_q    <= 1'b1;
      r_wrb_q    <= 1'b1;
      r_rd_pend  <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_hit   <= 1'b0;
      r_wr_pend  <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_rd_q     <= 1'b0;
      r_db_hold  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rdb_q <= bus.RDB;
      r_wrb_q <= bus.WRB;

      if (w_rd_start) begin
        r_rd_pend <= 1'b1;
        r_rd_addr <= bus.A[AW-1:0];
      end else if (w_gnt == GNT_CPU_RD) begin
        r_rd_pend <= 1'b0;
      end

      // Only a strobe that was seen inside the window may commit.
      if (w_wr_active) begin
        r_wr_hit  <= 1'b1;
        r_wr_addr <= bus.A[AW-1:0];
        r_wr_data <= bus.DB_I;
      end else if (w_wr_trail) begin
        r_wr_hit <= 1'b0;
      end

      if (w_wr_trail) begin
        r_wr_pend <= r_wr_hit;
      end else if (w_gnt == GNT_CPU_WR) begin
        r_wr_pend <= 1'b0;
      end

      r_rd_q <= (w_gnt == GNT_CPU_RD);
      if (r_rd_q) begin
        r_db_hold  <= w_ram_rdata;
        r_rd_valid <= 1'b1;
      end else if (w_rd_rise) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

  // The ack cycle masks a second grant while the requester is still high.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_vid_ack <= 1'b0;
      r_vid_d   <= '0;
      r_vid_dv  <= 1'b0;
    end else begin
      r_vid_ack <= (w_gnt == GNT_VID);
      r_vid_dv  <= r_vid_ack;
      if (r_vid_ack) begin
        r_vid_d <= w_ram_rdata;
      end
    end
  end

`ifdef SCV_VRAM_PORT_CLR_EN
  localparam logic [AW-1:0] c_CLR_LAST = '1;

  logic          r_busy;
  logic [AW-1:0] r_clr_addr;

  // Counter only advances on granted cycles, so CPU traffic pauses it.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_busy     <= 1'b1;
      r_clr_addr <= '0;
    end else if (w_gnt == GNT_CLR) begin
      if (r_clr_addr == c_CLR_LAST) begin
        r_busy <= 1'b0;
      end
      r_clr_addr <= r_clr_addr + 1'b1;
    end
  end

  assign w_clr_active = r_busy;
  assign w_clr_addr   = r_clr_addr;
`else
  assign w_clr_active = 1'b0;
  assign w_clr_addr   = '0;
`endif

  scv_spram #(
    .AW (AW),
    .DW (8)
  ) u_ram (
    .clk     (CLK),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign bus.DB_O    = r_db_hold;
  assign bus.DB_OE   = ~bus.RDB & w_sel & r_rd_valid;
  assign bus.VID_ACK = r_vid_ack;
  assign bus.VID_D   = r_vid_d;
  assign bus.VID_DV  = r_vid_dv;
  assign bus.BUSY    = w_clr_active;

endmodule
`default_nettype wire

// File: tb/tb_scv_vram_port.sv
`default_nettype none
// ============================================================================
// Module : tb_scv_vram_port
// Brief  : Directed self-checking bench for scv_vram_port (both SCV_VRAM_PORT_CLR_EN builds).
// Rev    : 1.0  initial release
// ============================================================================
module tb_scv_vram_port;

  logic CLK;
  logic RES;
  int   errors;
  int   checks;

  scv_vram_port_if #(.AW(10)) bus ();

  scv_vram_port #(
    .AW   (10),
    .BASE (16'h3000)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

`ifdef SCV_VRAM_PORT_CLR_EN
  localparam logic c_BUSY_RST = 1'b1;
  int busy_cnt;
  bit ack_in_busy;
  initial begin
    busy_cnt    = 0;
    ack_in_busy = 1'b0;
  end
  always @(negedge CLK) begin
    if (!RES && bus.BUSY) busy_cnt++;
    if (bus.BUSY && bus.VID_ACK) ack_in_busy = 1'b1;
  end
`else
  localparam logic c_BUSY_RST = 1'b0;
`endif

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
    bus.A    = addr;
    bus.DB_I = data;
    bus.WRB  = 1'b0;
    repeat (8) tick();
    bus.WRB = 1'b1;
    repeat (3) tick();
  endtask

  task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data, output logic oe);
    bus.A   = addr;
    bus.RDB = 1'b0;
    repeat (6) tick();
    data    = bus.DB_O;
    oe      = bus.DB_OE;
    bus.RDB = 1'b1;
    repeat (3) tick();
  endtask

  task automatic wait_not_busy();
    for (int i = 0; i < 3000 && bus.BUSY; i++) tick();
    checks++;
    if (bus.BUSY !== 1'b0) begin
      errors++;
      $display("FAIL busy_timeout: BUSY=%b after 3000 cycles, required 0", bus.BUSY);
    end
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.DB_O !== 8'h00) begin errors++; $display("FAIL rst_db_o: got %h exp 00", bus.DB_O); end
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL rst_db_oe: got %b exp 0", bus.DB_OE); end
    if (bus.VID_ACK !== 1'b0) begin errors++; $display("FAIL rst_vid_ack: got %b exp 0", bus.VID_ACK); end
    if (bus.VID_D !== 8'h00) begin errors++; $display("FAIL rst_vid_d: got %h exp 00", bus.VID_D); end
    if (bus.VID_DV !== 1'b0) begin errors++; $display("FAIL rst_vid_dv: got %b exp 0", bus.VID_DV); end
    if (bus.BUSY !== c_BUSY_RST) begin errors++; $display("FAIL rst_busy: got %b exp %b", bus.BUSY, c_BUSY_RST); end
  endtask

`ifdef SCV_VRAM_PORT_CLR_EN
  task automatic test_clear();
    logic [7:0] d;
    logic       oe;
    bus.VID_REQ = 1'b1;
    bus.VID_A   = 10'h005;
    cpu_write(16'h3000, 8'hAA);
    wait_not_busy();
    checks++;
    if (busy_cnt < 1024) begin errors++; $display("FAIL clr_busy_len: got %0d cycles exp >=1024", busy_cnt); end
    checks++;
    if (ack_in_busy !== 1'b0) begin errors++; $display("FAIL clr_ack_busy: got %b exp 0", ack_in_busy); end
    for (int i = 0; i < 4 && !bus.VID_ACK; i++) tick();
    checks++;
    if (bus.VID_ACK !== 1'b1) begin errors++; $display("FAIL clr_vid_ack: got %b exp 1", bus.VID_ACK); end
    bus.VID_REQ = 1'b0;
    tick();
    checks += 2;
    if (bus.VID_DV !== 1'b1) begin errors++; $display("FAIL clr_vid_dv: got %b exp 1", bus.VID_DV); end
    if (bus.VID_D !== 8'h00) begin errors++; $display("FAIL clr_vid_d: got %h exp 00", bus.VID_D); end
    cpu_read(16'h3000, d, oe);
    checks++;
    if (d !== 8'hAA || oe !== 1'b1) begin errors++; $display("FAIL clr_keep_aa: got %h oe=%b exp aa oe=1", d, oe); end
    cpu_read(16'h3001, d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL clr_3001: got %h oe=%b exp 00 oe=1", d, oe); end
    cpu_read(16'h33FF, d, oe);
    checks++;
    if (d !== 8'h00 || oe !== 1'b1) begin errors++; $display("FAIL clr_33ff: got %h oe=%b exp 00 oe=1", d, oe); end
  endtask
`endif

  task automatic test_write_read();
    logic [7:0] d;
    logic       oe;
    cpu_write(16'h3123, 8'h5A);
    bus.A   = 16'h3123;
    bus.RDB = 1'b0;
    tick();
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL wr_rd_oe_e1: got %b exp 0", bus.DB_OE); end
    tick();
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL wr_rd_oe_e2: got %b exp 0", bus.DB_OE); end
    tick();
    checks += 2;
    if (bus.DB_OE !== 1'b1) begin errors++; $display("FAIL wr_rd_oe_e3: got %b exp 1", bus.DB_OE); end
    if (bus.DB_O !== 8'h5A) begin errors++; $display("FAIL wr_rd_data: got %h exp 5a", bus.DB_O); end
    repeat (5) tick();
    bus.RDB = 1'b1;
    #1;
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL wr_rd_oe_rise: got %b exp 0", bus.DB_OE); end
    tick();
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL wr_rd_oe_after: got %b exp 0", bus.DB_OE); end
    repeat (2) tick();
    cpu_write(16'h33FF, 8'hA5);
    cpu_read(16'h33FF, d, oe);
    checks++;
    if (d !== 8'hA5 || oe !== 1'b1) begin errors++; $display("FAIL wr_rd_top: got %h oe=%b exp a5 oe=1", d, oe); end
    cpu_read(16'h3123, d, oe);
    checks++;
    if (d !== 8'h5A || oe !== 1'b1) begin errors++; $display("FAIL wr_rd_again: got %h oe=%b exp 5a oe=1", d, oe); end
  endtask

  task automatic test_out_of_window();
    logic [7:0] d;
    logic       oe;
    cpu_write(16'h3000, 8'h3C);
    cpu_write(16'h33FF, 8'hE1);
    cpu_read(16'h3400, d, oe);
    checks++;
    if (oe !== 1'b0) begin errors++; $display("FAIL oow_rd_oe: got %b exp 0", oe); end
    cpu_write(16'h2FFF, 8'h99);
    cpu_write(16'h3400, 8'h66);
    cpu_read(16'h3000, d, oe);
    checks++;
    if (d !== 8'h3C || oe !== 1'b1) begin errors++; $display("FAIL oow_keep_000: got %h oe=%b exp 3c oe=1", d, oe); end
    cpu_read(16'h33FF, d, oe);
    checks++;
    if (d !== 8'hE1 || oe !== 1'b1) begin errors++; $display("FAIL oow_keep_3ff: got %h oe=%b exp e1 oe=1", d, oe); end
  endtask

  task automatic test_video();
    cpu_write(16'h3010, 8'hC3);
    bus.A   = 16'h3123;
    bus.RDB = 1'b0;
    tick();
    bus.VID_A   = 10'h010;
    bus.VID_REQ = 1'b1;
    tick();
    checks++;
    if (bus.VID_ACK !== 1'b0) begin errors++; $display("FAIL vid_ack_early: got %b exp 0", bus.VID_ACK); end
    tick();
    checks += 3;
    if (bus.VID_ACK !== 1'b1) begin errors++; $display("FAIL vid_ack: got %b exp 1", bus.VID_ACK); end
    if (bus.DB_OE !== 1'b1) begin errors++; $display("FAIL vid_cpu_oe: got %b exp 1", bus.DB_OE); end
    if (bus.DB_O !== 8'h5A) begin errors++; $display("FAIL vid_cpu_data: got %h exp 5a", bus.DB_O); end
    tick();
    checks += 3;
    if (bus.VID_ACK !== 1'b0) begin errors++; $display("FAIL vid_ack_pulse: got %b exp 0", bus.VID_ACK); end
    if (bus.VID_DV !== 1'b1) begin errors++; $display("FAIL vid_dv: got %b exp 1", bus.VID_DV); end
    if (bus.VID_D !== 8'hC3) begin errors++; $display("FAIL vid_d: got %h exp c3", bus.VID_D); end
    bus.VID_REQ = 1'b0;
    tick();
    checks += 2;
    if (bus.VID_DV !== 1'b0) begin errors++; $display("FAIL vid_dv_pulse: got %b exp 0", bus.VID_DV); end
    if (bus.DB_O !== 8'h5A) begin errors++; $display("FAIL vid_cpu_hold: got %h exp 5a", bus.DB_O); end
    bus.RDB = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    cpu_write(16'h3001, 8'h12);
    bus.A    = 16'h3001;
    bus.DB_I = 8'h77;
    bus.WRB  = 1'b0;
    repeat (8) tick();
    bus.WRB = 1'b1;
    bus.RDB = 1'b0;
    repeat (2) tick();
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL sim_oe_e2: got %b exp 0", bus.DB_OE); end
    tick();
    checks++;
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL sim_oe_e3: got %b exp 0", bus.DB_OE); end
    tick();
    checks += 2;
    if (bus.DB_OE !== 1'b1) begin errors++; $display("FAIL sim_oe_e4: got %b exp 1", bus.DB_OE); end
    if (bus.DB_O !== 8'h77) begin errors++; $display("FAIL sim_data: got %h exp 77", bus.DB_O); end
    bus.RDB = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_reset_mid_write();
    logic [7:0] d;
    logic       oe;
    logic [7:0] exp_d;
`ifdef SCV_VRAM_PORT_CLR_EN
    exp_d = 8'h00;
`else
    exp_d = 8'h4D;
`endif
    cpu_write(16'h3200, 8'h4D);
    cpu_read(16'h3123, d, oe);
    bus.A    = 16'h3200;
    bus.DB_I = 8'hB2;
    bus.WRB  = 1'b0;
    repeat (4) tick();
    RES = 1'b1;
    repeat (2) tick();
    bus.WRB = 1'b1;
    tick();
    RES = 1'b0;
    tick();
    checks += 5;
    if (bus.DB_O !== 8'h00) begin errors++; $display("FAIL mid_db_o: got %h exp 00", bus.DB_O); end
    if (bus.DB_OE !== 1'b0) begin errors++; $display("FAIL mid_db_oe: got %b exp 0", bus.DB_OE); end
    if (bus.VID_ACK !== 1'b0) begin errors++; $display("FAIL mid_vid_ack: got %b exp 0", bus.VID_ACK); end
    if (bus.VID_D !== 8'h00) begin errors++; $display("FAIL mid_vid_d: got %h exp 00", bus.VID_D); end
    if (bus.VID_DV !== 1'b0) begin errors++; $display("FAIL mid_vid_dv: got %b exp 0", bus.VID_DV); end
    checks++;
    if (bus.BUSY !== c_BUSY_RST) begin errors++; $display("FAIL mid_busy: got %b exp %b", bus.BUSY, c_BUSY_RST); end
    wait_not_busy();
    cpu_read(16'h3200, d, oe);
    checks++;
    if (d !== exp_d || oe !== 1'b1) begin errors++; $display("FAIL mid_location: got %h oe=%b exp %h oe=1", d, oe, exp_d); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    RES         = 1'b1;
    bus.A       = 16'h0000;
    bus.DB_I    = 8'h00;
    bus.RDB     = 1'b1;
    bus.WRB     = 1'b1;
    bus.VID_REQ = 1'b0;
    bus.VID_A   = '0;
    repeat (3) tick();
    test_reset();
    RES = 1'b0;
    tick();
`ifdef SCV_VRAM_PORT_CLR_EN
    test_clear();
`endif
    test_write_read();
    test_out_of_window();
    test_video();
    test_back_to_back();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit, required finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
